// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one LW/SW at a time over valid/ready channels,
// fixed wait states, word array access. Optional address checking under DMEM_ERR_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | request latched, counting wait states
    // RESP  | response presented until rsp_ready
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              valid_q;
    logic [31:0]       rdata_q;
    logic              rsp_err_q;
    logic              req_err;
    logic              accept;
    logic              enter_resp;
    logic              rsp_done;

    logic [31:0] mem_q [DEPTH_WORDS];

`ifdef DMEM_ERR_CHECK_EN
    assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= 32'(4 * DEPTH_WORDS));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[31:ADDR_W+2], req_addr_i[1:0]};
    assign req_err = 1'b0;
`endif

    assign accept     = (state_q == ST_IDLE) && req_valid_i;
    assign enter_resp = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign rsp_done   = (state_q == ST_RESP) && rsp_ready_i;

    // Every request passes through WAIT for WAIT_STATES+1 cycles, so the array access
    // (and rsp_valid) lands WAIT_STATES+1 edges after the accept edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write_i;
                idx_q   <= req_addr_i[ADDR_W+1:2];
                wdata_q <= req_wdata_i;
                err_q   <= req_err;
            end
            if (enter_resp) begin
                valid_q   <= 1'b1;
                rdata_q   <= (wr_q || err_q) ? 32'd0 : mem_q[idx_q];
                rsp_err_q <= err_q;
            end else if (rsp_done) begin
                valid_q   <= 1'b0;
                rdata_q   <= 32'd0;
                rsp_err_q <= 1'b0;
            end
        end
    end

    // Array contents survive reset; a store commits only on the RESP entry edge.
    always_ff @(posedge clock_i) begin
        if (enter_resp && wr_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
`ifdef DMEM_ERR_CHECK_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT_STATES=2 and one with 0.
// Expectations adapt to DMEM_ERR_CHECK_EN through the reference model.
module tb_dmem_responder;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t        sb_q [$];
    logic [31:0] mdl_mem [int];
    int          n_chk;
    int          n_fail;

    dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(2)) u_ws2 (
        .clock_i(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_write_i(req_write[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
        .clock_i(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_write_i(req_write[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Reference model: byte address -> word index modulo 1024, separate array per instance.
    task automatic model_push(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata);
        exp_t e;
        int   key;
        bit   err;
        key = d * 4096 + int'(addr[11:2]);
        err = ERR_EN && ((addr[1:0] != 2'b00) || (addr >= 32'h0000_1000));
        e.err = err;
        e.rd  = 32'd0;
        if (!err) begin
            if (wr) begin
                mdl_mem[key] = wdata;
            end else if (mdl_mem.exists(key)) begin
                e.rd = mdl_mem[key];
            end
        end
        sb_q.push_back(e);
    endtask

    // Called and returns at a negedge; drives one request, checks latency, hold and release.
    task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        int   lat;
        exp_t e;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        lat = 0;
        while (!req_ready[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        model_push(d, wr, addr, wdata);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        @(negedge clk);
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(1 + ws_of(d)));
        chk("sb_size", 32'(sb_q.size()), 32'd1);
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata[d], e.rd);
        chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
        chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_rdata", rsp_rdata[d], e.rd);
            chk("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
        chk("idle_after_rsp", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            rsp_ready[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // store then load back, 3-cycle latency with two wait states
        do_req(0, 1'b1, 32'h0000_0040, 32'h1234_5678, 0);
        do_req(0, 1'b0, 32'h0000_0040, 32'h0, 0);
        // stalled response must hold
        do_req(0, 1'b0, 32'h0000_0040, 32'h0, 5);

        // reset in the middle of a store's WAIT drops the store
        do_req(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0010;
        req_wdata[0] = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("in_wait_ready", 32'(req_ready[0]), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_req(0, 1'b0, 32'h0000_0010, 32'h0, 0);

        // zero wait states, back-to-back loads
        do_req(1, 1'b1, 32'h0000_0000, 32'hA0A0_A0A0, 0);
        do_req(1, 1'b1, 32'h0000_0004, 32'hB4B4_B4B4, 0);
        do_req(1, 1'b0, 32'h0000_0000, 32'h0, 0);
        do_req(1, 1'b0, 32'h0000_0004, 32'h0, 0);

        // aliasing / error addresses; the model decides which applies
        do_req(0, 1'b1, 32'h0000_0004, 32'h0000_0055, 0);
        do_req(0, 1'b1, 32'h0000_1004, 32'h0000_00AA, 0);
        do_req(0, 1'b0, 32'h0000_0004, 32'h0, 0);
        do_req(0, 1'b1, 32'h0000_0000, 32'h0000_1234, 0);
        do_req(0, 1'b0, 32'h0000_0002, 32'h0, 0);
        do_req(0, 1'b1, 32'h0000_1000, 32'h0000_9999, 0);
        do_req(0, 1'b0, 32'h0000_0000, 32'h0, 0);

        // random aligned stores with read-back on the zero-wait instance
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] v;
            a = {20'd0, 10'($urandom), 2'b00};
            v = $urandom;
            do_req(1, 1'b1, a, v, 0);
            do_req(1, 1'b0, a, 32'h0, (i == 2) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
